prog_counter_seq: RTL and testbench

Job sequencer that drives the control inputs of the 8-bit programmable counter: LOAD, EN, UP, OE and the parallel-load value. It accepts one command at a time through a valid/ready handshake. Each command loads a start value, then issues a programmed number of count steps in a chosen direction, spaced by a programmable prescale interval. It tracks counter wrap events during the job and signals completion with a one-cycle done pulse.

---
 rtl/prog_counter_seq.sv | 170 +++++++++++++++++
 tb/tb_prog_counter_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter_seq.sv
// Job sequencer for an 8-bit programmable counter: load, N prescaled steps, done pulse.
// Optional AUTO_RELOAD_EN: a job latched with cmd_repeat=1 replays until abort or reset.
module prog_counter_seq #(
    parameter int unsigned PRESCALE_W = 4,
    parameter int unsigned WRAPCNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_start,
    input  logic [7:0]            cmd_len,
    input  logic                  cmd_up,
    input  logic [PRESCALE_W-1:0] cmd_div,
    input  logic                  cmd_repeat,
    input  logic                  abort,
    input  logic                  oe_force,
    input  logic                  ctr_wrap,
    output logic                  ctr_load,
    output logic [7:0]            ctr_load_val,
    output logic                  ctr_en,
    output logic                  ctr_up,
    output logic                  ctr_oe,
    output logic                  busy,
    output logic                  done,
    output logic [WRAPCNT_W-1:0]  wrap_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] div_q, div_d;
    logic [7:0]            start_q, start_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            remain_q, remain_d;
    logic                  up_q, up_d;
    logic [WRAPCNT_W-1:0]  wrap_cnt_q, wrap_cnt_d;
    logic                  accept;
    logic                  wrap_window;

`ifdef AUTO_RELOAD_EN
    logic repeat_q, repeat_d;
`else
    logic unused_cmd_repeat;
    assign unused_cmd_repeat = cmd_repeat;
`endif

    // abort in IDLE does nothing except block the accept of that cycle
    assign accept      = (state_q == StIdle) && cmd_valid && !abort;
    assign wrap_window = (state_q == StRun) || (state_q == StDone);

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        div_d      = div_q;
        start_d    = start_q;
        len_d      = len_q;
        remain_d   = remain_q;
        up_d       = up_q;
        wrap_cnt_d = wrap_cnt_q;
`ifdef AUTO_RELOAD_EN
        repeat_d   = repeat_q;
`endif
        cmd_ready  = 1'b0;
        ctr_load   = 1'b0;
        ctr_en     = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (accept) begin
                    start_d    = cmd_start;
                    len_d      = cmd_len;
                    up_d       = cmd_up;
                    div_d      = cmd_div;
`ifdef AUTO_RELOAD_EN
                    repeat_d   = cmd_repeat;
`endif
                    wrap_cnt_d = '0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                ctr_load = 1'b1;
                presc_d  = '0;
                remain_d = len_q;
                state_d  = (len_q == 8'd0) ? StDone : StRun;
            end
            StRun: begin
                if (presc_q == div_q) begin
                    ctr_en   = 1'b1;
                    presc_d  = '0;
                    remain_d = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        state_d = StDone;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
`ifdef AUTO_RELOAD_EN
                if (repeat_q) begin
                    state_d = StLoad;
                end
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // DONE is included so the wrap caused by the final step is still counted
        if (wrap_window && ctr_wrap && !abort && (wrap_cnt_q != {WRAPCNT_W{1'b1}})) begin
            wrap_cnt_d = wrap_cnt_q + 1'b1;
        end

        if (abort && (state_q != StIdle)) begin
            state_d  = StIdle;
            presc_d  = '0;
            ctr_load = 1'b0;
            ctr_en   = 1'b0;
            done     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            div_q      <= '0;
            start_q    <= 8'd0;
            len_q      <= 8'd0;
            remain_q   <= 8'd0;
            up_q       <= 1'b0;
            wrap_cnt_q <= '0;
`ifdef AUTO_RELOAD_EN
            repeat_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            div_q      <= div_d;
            start_q    <= start_d;
            len_q      <= len_d;
            remain_q   <= remain_d;
            up_q       <= up_d;
            wrap_cnt_q <= wrap_cnt_d;
`ifdef AUTO_RELOAD_EN
            repeat_q   <= repeat_d;
`endif
        end
    end

    assign busy         = (state_q != StIdle);
    assign ctr_up       = busy & up_q;
    assign ctr_oe       = busy | oe_force;
    assign ctr_load_val = start_q;
    assign wrap_cnt     = wrap_cnt_q;

endmodule

// File: tb/tb_prog_counter_seq.sv
// Directed bench for prog_counter_seq with a small behavioural 8-bit counter as the load.
// Define AUTO_RELOAD_EN for both files to exercise the repeat path.
module tb_prog_counter_seq;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_start;
    logic [7:0] cmd_len;
    logic       cmd_up;
    logic [3:0] cmd_div;
    logic       cmd_repeat;
    logic       abort;
    logic       oe_force;
    logic       ctr_wrap;
    logic       ctr_load;
    logic [7:0] ctr_load_val;
    logic       ctr_en;
    logic       ctr_up;
    logic       ctr_oe;
    logic       busy;
    logic       done;
    logic [3:0] wrap_cnt;

    int n_checks;
    int n_errors;

    logic [31:0] en_m, ld_m, dn_m, up_m, rdy_m;

    prog_counter_seq #(
        .PRESCALE_W (4),
        .WRAPCNT_W  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_start    (cmd_start),
        .cmd_len      (cmd_len),
        .cmd_up       (cmd_up),
        .cmd_div      (cmd_div),
        .cmd_repeat   (cmd_repeat),
        .abort        (abort),
        .oe_force     (oe_force),
        .ctr_wrap     (ctr_wrap),
        .ctr_load     (ctr_load),
        .ctr_load_val (ctr_load_val),
        .ctr_en       (ctr_en),
        .ctr_up       (ctr_up),
        .ctr_oe       (ctr_oe),
        .busy         (busy),
        .done         (done),
        .wrap_cnt     (wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter being driven; wrap pulse appears the cycle after the wrapping step.
    logic [7:0] cnt;
    logic       wrap_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 8'd0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (ctr_load) begin
                cnt <= ctr_load_val;
            end else if (ctr_en) begin
                if (ctr_up) begin
                    cnt    <= cnt + 8'd1;
                    wrap_q <= (cnt == 8'hFF);
                end else begin
                    cnt    <= cnt - 8'd1;
                    wrap_q <= (cnt == 8'h00);
                end
            end
        end
    end
    assign ctr_wrap = wrap_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Call in cycle T (2 time units past a rising edge, block idle). Bit k of each mask
    // records the output in cycle T+k, for k = 1..n.
    task automatic run_job(input logic [7:0] s, input logic [7:0] l, input logic u,
                           input logic [3:0] d, input logic r, input int n,
                           input int abort_at, input int rst_at);
        en_m = '0; ld_m = '0; dn_m = '0; up_m = '0; rdy_m = '0;
        cmd_start  = s;
        cmd_len    = l;
        cmd_up     = u;
        cmd_div    = d;
        cmd_repeat = r;
        cmd_valid  = 1'b1;
        #1;
        check("ready_at_accept", cmd_ready, 1'b1);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            abort     = (k == abort_at);
            if (k == rst_at) rst_n = 1'b0;
            #1;
            if (k < 32) begin
                en_m[k]  = ctr_en;
                ld_m[k]  = ctr_load;
                dn_m[k]  = done;
                up_m[k]  = ctr_up;
                rdy_m[k] = cmd_ready;
            end
        end
        abort = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_start  = 8'd0;
        cmd_len    = 8'd0;
        cmd_up     = 1'b0;
        cmd_div    = 4'd0;
        cmd_repeat = 1'b0;
        abort      = 1'b0;
        oe_force   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_outs", {ctr_load, ctr_en, ctr_up, ctr_oe, done}, 5'b0);
        check("rst_wrap", wrap_cnt, 4'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #2;

        oe_force = 1'b1;
        #1 check("oe_force_idle", ctr_oe, 1'b1);
        oe_force = 1'b0;
        #1 check("oe_idle", ctr_oe, 1'b0);

        // abort in IDLE blocks the accept
        cmd_valid = 1'b1;
        abort     = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        abort = 1'b0;
        #1 check("idle_abort_blocks", busy, 1'b0);

        // Basic up
        run_job(8'h10, 8'd3, 1'b1, 4'd0, 1'b0, 6, 0, 0);
        check("basic_load", ld_m, 32'h2);
        check("basic_en", en_m, 32'h1C);
        check("basic_done", dn_m, 32'h20);
        check("basic_up", up_m, 32'h3E);
        check("basic_ready", rdy_m, 32'h40);
        check("basic_cnt", cnt, 8'h13);
        check("basic_wrap", wrap_cnt, 4'd0);
        check("basic_ldval", ctr_load_val, 8'h10);

        // Down through zero
        run_job(8'h01, 8'd3, 1'b0, 4'd0, 1'b0, 6, 0, 0);
        check("down_en", en_m, 32'h1C);
        check("down_done", dn_m, 32'h20);
        check("down_up", up_m, 32'h0);
        check("down_cnt", cnt, 8'hFE);
        check("down_wrap", wrap_cnt, 4'd1);

        // Prescale div=2
        run_job(8'h00, 8'd2, 1'b1, 4'd2, 1'b0, 9, 0, 0);
        check("presc_en", en_m, 32'h90);
        check("presc_done", dn_m, 32'h100);
        check("presc_ready", rdy_m, 32'h200);
        check("presc_cnt", cnt, 8'h02);

        // Zero length
        run_job(8'hAA, 8'd0, 1'b1, 4'd0, 1'b0, 3, 0, 0);
        check("zero_load", ld_m, 32'h2);
        check("zero_en", en_m, 32'h0);
        check("zero_done", dn_m, 32'h4);
        check("zero_ready", rdy_m, 32'h8);
        check("zero_cnt", cnt, 8'hAA);

        // Abort at T+4
        run_job(8'h20, 8'd10, 1'b1, 4'd0, 1'b0, 5, 4, 0);
        check("abort_en", en_m, 32'hC);
        check("abort_done", dn_m, 32'h0);
        check("abort_ready", rdy_m, 32'h20);
        check("abort_busy", busy, 1'b0);
        check("abort_cnt", cnt, 8'h22);
        check("abort_wrap", wrap_cnt, 4'd0);

        // Reset at T+4: outputs return to reset values at once
        run_job(8'h20, 8'd10, 1'b1, 4'd0, 1'b0, 4, 0, 4);
        check("rstrun_ready", cmd_ready, 1'b1);
        check("rstrun_busy", busy, 1'b0);
        check("rstrun_outs", {ctr_load, ctr_en, ctr_up, ctr_oe, done}, 5'b0);
        check("rstrun_ldval", ctr_load_val, 8'h00);
        check("rstrun_wrap", wrap_cnt, 4'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #2;

`ifdef AUTO_RELOAD_EN
        run_job(8'hFE, 8'd2, 1'b1, 4'd0, 1'b1, 10, 9, 0);
        check("rep_load", ld_m, 32'h22);
        check("rep_en", en_m, 32'hCC);
        check("rep_done", dn_m, 32'h110);
        check("rep_ready", rdy_m, 32'h400);
        check("rep_wrap", wrap_cnt, 4'd2);
        check("rep_busy", busy, 1'b0);
`else
        run_job(8'hFE, 8'd2, 1'b1, 4'd0, 1'b1, 5, 0, 0);
        check("norep_load", ld_m, 32'h2);
        check("norep_en", en_m, 32'hC);
        check("norep_done", dn_m, 32'h10);
        check("norep_ready", rdy_m, 32'h20);
        check("norep_wrap", wrap_cnt, 4'd1);
        check("norep_cnt", cnt, 8'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
